// File: rtl/adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package adder_pkg;

  // Controller state, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter able to hold the values 0..w; stays >= 1 bit when w == 1.
  function automatic int cnt_w(input int w);
    return $clog2(w + 32'sd1);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder, the shared arithmetic resource.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: runs one full-adder cell over WIDTH cycles
// to form {cout,sum} = a + b + cin behind a start/busy/done handshake.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH:0]   w_sum_ext;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;

  fa_cell u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // New sum bit enters at the MSB, so after WIDTH steps bit 0 of the
  // operands has landed in bit 0 of the result.
  assign w_sum_ext  = {w_fa_sum, r_sum_sh};
  assign w_sum_next = WIDTH'(w_sum_ext >> 1);
  assign w_last     = (r_cnt == CNT_LAST);

  // Next-state logic: start only matters in IDLE; DONE always lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = RUN;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register with synchronous reset taking priority over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand capture, serial shifting and result publication on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next;
          r_carry  <= w_fa_cout;
          r_cnt    <= r_cnt + CNT_ONE;
          if (w_last) begin
            r_sum  <= w_sum_next;
            r_cout <= w_fa_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake flags registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state != IDLE);
      r_done <= (w_next_state == DONE);
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;

  // Reference results the DUT outputs must be holding.
  logic [7:0] m_sum8;
  logic       m_cout8;
  logic       m_sum1;
  logic       m_cout1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation; poke_at >= 0 fires a rival start in that RUN cycle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int poke_at);
    logic [8:0] exp_res;
    int k;
    exp_res = 9'(a) + 9'(b) + 9'(c);
    for (int i = 0; i < 40 && busy8 === 1'b1; i++) tick();
    chk("idle_before_start", busy8, 1'b0);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    tick();
    start8 = 1'b0;
    k = 0;
    while (done8 !== 1'b1 && k < 40) begin
      chk("busy_in_run", busy8, 1'b1);
      chk("result_held_in_run", {cout8, sum8}, {m_cout8, m_sum8});
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      if (k == poke_at) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      tick();
      k++;
    end
    start8 = 1'b0;
    chk("latency8", k, 8);
    chk("busy_in_done", busy8, 1'b1);
    chk("result8", {cout8, sum8}, exp_res);
    m_sum8  = exp_res[7:0];
    m_cout8 = exp_res[8];
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_pulse_ended", done8, 1'b0);
      chk("busy_after_done", busy8, 1'b0);
    end
    chk("result8_held_idle", {cout8, sum8}, {m_cout8, m_sum8});
  endtask

  // One WIDTH=1 operation: a registered full adder with handshake.
  task automatic op1(input logic a, input logic b, input logic c);
    logic [1:0] exp_res;
    int k;
    exp_res = 2'(a) + 2'(b) + 2'(c);
    for (int i = 0; i < 40 && busy1 === 1'b1; i++) tick();
    chk("idle1_before_start", busy1, 1'b0);
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    tick();
    start1 = 1'b0;
    k = 0;
    while (done1 !== 1'b1 && k < 40) begin
      chk("busy1_in_run", busy1, 1'b1);
      chk("result1_held_in_run", {cout1, sum1}, {m_cout1, m_sum1});
      a1 = ~a; b1 = ~b; cin1 = ~c;
      tick();
      k++;
    end
    chk("latency1", k, 1);
    chk("result1", {cout1, sum1}, exp_res);
    m_sum1  = exp_res[0];
    m_cout1 = exp_res[1];
    tick();
    chk("done1_pulse_ended", done1, 1'b0);
    chk("busy1_after_done", busy1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int q_done[$];

    rst = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    m_sum8 = 8'h00; m_cout8 = 1'b0; m_sum1 = 1'b0; m_cout1 = 1'b0;
    repeat (3) tick();
    chk("reset_busy8", busy8, 1'b0);
    chk("reset_done8", done8, 1'b0);
    chk("reset_result8", {cout8, sum8}, 9'h000);
    chk("reset_busy1", busy1, 1'b0);
    chk("reset_result1", {done1, cout1, sum1}, 3'b000);
    rst = 1'b0;
    tick();

    // Zero operands, then carry-out and carry-in cases.
    op8(8'h00, 8'h00, 1'b0, -1);
    op8(8'hFF, 8'h01, 1'b0, -1);
    op8(8'h3C, 8'h42, 1'b1, -1);

    // Rival start in RUN cycle 3 must be ignored.
    op8(8'h10, 8'h20, 1'b0, 2);

    // Reset in RUN cycle 4 aborts the operation without a done pulse.
    start8 = 1'b1; a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_sum8 = 8'h00; m_cout8 = 1'b0; m_sum1 = 1'b0; m_cout1 = 1'b0;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_result", {cout8, sum8}, 9'h000);
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_done", done8, 1'b0);
      tick();
    end
    op8(8'h01, 8'h01, 1'b0, -1);

    // Reset beats start; then a held start gives back-to-back operations.
    rst = 1'b1; start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    tick();
    chk("rst_over_start_busy", busy8, 1'b0);
    chk("rst_over_start_done", done8, 1'b0);
    rst = 1'b0;
    m_sum8 = 8'h00; m_cout8 = 1'b0; m_sum1 = 1'b0; m_cout1 = 1'b0;
    for (t = 1; t <= 40; t++) begin
      tick();
      if (done8 === 1'b1) begin
        q_done.push_back(t);
        chk("b2b_result", {cout8, sum8}, 9'h046);
      end
    end
    start8 = 1'b0;
    chk("b2b_count", q_done.size(), 4);
    for (int i = 0; i < q_done.size(); i++) chk("b2b_done_time", q_done[i], 9 + 10 * i);
    m_sum8 = 8'h46; m_cout8 = 1'b0;

    // Random operands against plain arithmetic.
    for (int i = 0; i < 16; i++) op8(8'($urandom), 8'($urandom), 1'($urandom), -1);

    // WIDTH=1 truth-table sweep.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] bits;
      bits = 3'(v);
      op1(bits[2], bits[1], bits[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
